// File: rtl/uart_tx_feeder_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_pkg
//
// Shared definitions for the UART transmit feeder:
//   - 2-bit encodings of the launcher FSM states (IDLE / LAUNCH / WAIT)
//   - the enumerated state type built on those encodings
//   - a helper returning the FIFO depth for a given address width
// ---------------------------------------------------------------------------
package uart_tx_feeder_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LAUNCH = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_LAUNCH = LAUNCH,
        ST_WAIT   = WAIT
    } feeder_state_e;

    // Number of FIFO entries addressed by an addr_w-bit pointer.
    function automatic int fifo_depth(input int addr_w);
        return 2 ** addr_w;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// ---------------------------------------------------------------------------
// tx_fifo_regs
//
// Small circular FIFO built from registers, used by uart_tx_feeder to queue
// bytes ahead of the UART transmitter.
//
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-high reset (clears pointers/count/tick)
//   wr_i        write strobe; accepted only when not full
//   wr_data_i   data to enqueue
//   rd_i        pop strobe; honoured only when not empty
//   rd_data_o   current head entry (valid whenever not empty)
//   full_o      FIFO holds 2**ADDR_W entries
//   empty_o     FIFO holds no entries
//   ovf_tick_o  registered one-cycle pulse after a write was rejected (full)
// ---------------------------------------------------------------------------
module tx_fifo_regs
    import uart_tx_feeder_pkg::*;
#(
    parameter int D_BIT  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              wr_i,
    input  logic [D_BIT-1:0]  wr_data_i,
    input  logic              rd_i,
    output logic [D_BIT-1:0]  rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_tick_o
);

    localparam int               DEPTH     = fifo_depth(ADDR_W);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [D_BIT-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              ovf_tick_q, ovf_tick_d;

    logic              wr_accept;
    logic              rd_accept;

    // Full/empty come straight from the count register, so a write that
    // coincides with a pop while full is still rejected.
    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign ovf_tick_o = ovf_tick_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    assign wr_accept  = wr_i && !full_o;
    assign rd_accept  = rd_i && !empty_o;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_tick_d = wr_i && full_o;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Simultaneous accepted write and pop leaves the occupancy unchanged.
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_tick_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_tick_q <= ovf_tick_d;
        end
    end

    // Storage is not reset: contents are meaningless until written, and the
    // count guards every read.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//
// Buffer and launcher sitting in front of the UART transmitter. Producers
// write bytes with a strobe; they are queued in tx_fifo_regs and handed to
// the transmitter one at a time with a single-cycle start pulse. The next
// byte is only launched after the transmitter's done tick.
//
// Ports:
//   i_clk           system clock
//   i_reset         asynchronous active-high reset, shared with transmitter
//   i_wr            write strobe (one byte per cycle while high)
//   i_wr_data       byte to enqueue
//   o_full          queue full
//   o_empty         queue empty
//   o_ovf_tick      one-cycle pulse: a write was dropped because queue full
//   o_tx_start      to transmitter i_tx_start; one cycle per byte
//   o_tx_data       to transmitter i_data; registered at pop, held until next
//   i_tx_done_tick  from transmitter o_tx_done_tick
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int D_BIT  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr,
    input  logic [D_BIT-1:0]  i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_ovf_tick,
    output logic              o_tx_start,
    output logic [D_BIT-1:0]  o_tx_data,
    input  logic              i_tx_done_tick
);

    feeder_state_e     state_q, state_d;
    logic [D_BIT-1:0]  tx_data_q, tx_data_d;
    logic              pop;

    logic [D_BIT-1:0]  fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_ovf_tick;

    tx_fifo_regs #(
        .D_BIT  (D_BIT),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .wr_i       (i_wr),
        .wr_data_i  (i_wr_data),
        .rd_i       (pop),
        .rd_data_o  (fifo_rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .ovf_tick_o (fifo_ovf_tick)
    );

    // Launcher: pop on IDLE->LAUNCH, pulse start for exactly the LAUNCH
    // cycle, then park in WAIT until the transmitter reports completion.
    // The done tick only matters in WAIT.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rd_data;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    // All outputs are decoded from registers only.
    assign o_tx_start = (state_q == ST_LAUNCH);
    assign o_tx_data  = tx_data_q;
    assign o_full     = fifo_full;
    assign o_empty    = fifo_empty;
    assign o_ovf_tick = fifo_ovf_tick;

endmodule
